// File: rtl/uart_alu_frontend.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, presents
// them to the ALU, then hands the latched result to the UART transmitter.
module uart_alu_frontend #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_drop
);

    localparam logic [4:0] WAIT_A  = 5'b00001;
    localparam logic [4:0] WAIT_B  = 5'b00010;
    localparam logic [4:0] WAIT_OP = 5'b00100;
    localparam logic [4:0] SEND    = 5'b01000;
    localparam logic [4:0] WAIT_TX = 5'b10000;

    logic [4:0] state_reg;

    assign o_busy = (state_reg == SEND) || (state_reg == WAIT_TX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= WAIT_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            // Bytes arriving while the result is in flight are lost; flag it for good.
            if (i_valid && o_busy) begin
                o_drop <= 1'b1;
            end
            case (state_reg)
                WAIT_A: begin
                    if (i_valid) begin
                        o_data_a  <= i_data;
                        state_reg <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_valid) begin
                        o_data_b  <= i_data;
                        state_reg <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (i_valid) begin
                        o_op      <= i_data[NB_OP-1:0];
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    o_tx_data  <= i_result;
                    o_tx_start <= 1'b1;
                    state_reg  <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state_reg <= WAIT_A;
                    end
                end
                default: begin
                    state_reg <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_frontend.sv
// Directed bench for uart_alu_frontend with a small ADD-only ALU model.
module tb_uart_alu_frontend;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic [7:0] result;
    logic       tx_done;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       drop;

    int total;
    int passed;
    int start_count;

    uart_alu_frontend #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_data     (data),
        .i_valid    (valid),
        .i_result   (result),
        .i_tx_done  (tx_done),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_op       (op),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_drop     (drop)
    );

    // ALU model: opcode 0x20 is ADD, anything else yields zero.
    assign result = (op == 6'h20) ? (data_a + data_b) : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start) start_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        tick();
        valid = 1'b0;
        data  = 8'h00;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data    = 8'($urandom);
            valid   = 1'($urandom);
            tx_done = 1'($urandom);
            tick();
        end
        reset = 1'b0; valid = 1'b0; data = 8'h00; tx_done = 1'b0;
        total++;
        if ({data_a, data_b, op, tx_data, tx_start, busy, drop} !== 33'd0)
            $display("FAIL reset_outputs: got a=%h b=%h op=%h tx=%h st=%b busy=%b drop=%b, want all 0",
                     data_a, data_b, op, tx_data, tx_start, busy, drop);
        else passed++;
        $display("reset: outputs a=%h b=%h op=%h tx=%h", data_a, data_b, op, tx_data);
    endtask

    task automatic test_basic();
        send_byte(8'h05); tick();
        total++; if (data_a !== 8'h05) $display("FAIL basic_a: got %h want 05", data_a); else passed++;
        send_byte(8'h03); tick(); tick();
        total++; if (data_b !== 8'h03) $display("FAIL basic_b: got %h want 03", data_b); else passed++;
        send_byte(8'h20);
        total++; if (op !== 6'h20) $display("FAIL basic_op: got %h want 20", op); else passed++;
        total++; if (busy !== 1'b1 || tx_start !== 1'b0)
            $display("FAIL basic_send: busy=%b start=%b want 1/0", busy, tx_start); else passed++;
        tick();
        total++; if (tx_start !== 1'b1 || tx_data !== 8'h08)
            $display("FAIL basic_start: start=%b tx=%h want 1/08", tx_start, tx_data); else passed++;
        tick();
        total++; if (tx_start !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_wait: start=%b busy=%b want 0/1", tx_start, busy); else passed++;
        tick(); tick();
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_hold: got %b want 1", busy); else passed++;
        pulse_done();
        total++; if (busy !== 1'b0 || drop !== 1'b0)
            $display("FAIL basic_idle: busy=%b drop=%b want 0/0", busy, drop); else passed++;
        $display("basic: a=05 b=03 op=20 -> tx=%h", tx_data);
    endtask

    task automatic test_back_to_back();
        valid = 1'b1;
        data = 8'hFF; tick();
        data = 8'h01; tick();
        data = 8'hE0; tick();
        valid = 1'b0; data = 8'h00;
        total++; if (data_a !== 8'hFF || data_b !== 8'h01 || op !== 6'h20)
            $display("FAIL b2b_operands: a=%h b=%h op=%h want FF/01/20", data_a, data_b, op); else passed++;
        tick();
        total++; if (tx_start !== 1'b1 || tx_data !== 8'h00)
            $display("FAIL b2b_start: start=%b tx=%h want 1/00", tx_start, tx_data); else passed++;
        tick();
        total++; if (tx_start !== 1'b0) $display("FAIL b2b_single: start=%b want 0", tx_start); else passed++;
        $display("b2b: a=FF b=01 op=E0 -> op=%h tx=%h", op, tx_data);
    endtask

    task automatic test_drop();
        // Still in WAIT_TX from the back-to-back frame.
        send_byte(8'h77);
        total++; if (drop !== 1'b1) $display("FAIL drop_set: got %b want 1", drop); else passed++;
        total++; if (data_a !== 8'hFF || data_b !== 8'h01 || op !== 6'h20 || busy !== 1'b1)
            $display("FAIL drop_hold: a=%h b=%h op=%h busy=%b want FF/01/20/1", data_a, data_b, op, busy);
        else passed++;
        pulse_done();
        send_byte(8'h10); send_byte(8'h22); send_byte(8'h20); tick();
        total++; if (tx_start !== 1'b1 || tx_data !== 8'h32)
            $display("FAIL drop_frame: start=%b tx=%h want 1/32", tx_start, tx_data); else passed++;
        pulse_done();
        total++; if (drop !== 1'b1) $display("FAIL drop_sticky: got %b want 1", drop); else passed++;
        $display("drop: byte 77 in WAIT_TX, drop=%b", drop);
    endtask

    task automatic test_done_edge();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h20);
        tick();
        // First WAIT_TX cycle: start is high and done arrives at once.
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL done_first: busy=%b want 0", busy); else passed++;
        send_byte(8'h11);
        total++; if (data_a !== 8'h11) $display("FAIL done_capture_a: got %h want 11", data_a); else passed++;
        pulse_done();
        total++; if (busy !== 1'b0 || data_b !== 8'h02)
            $display("FAIL done_ignored: busy=%b b=%h want 0/02", busy, data_b); else passed++;
        send_byte(8'h22);
        total++; if (data_b !== 8'h22 || op !== 6'h20 || busy !== 1'b0)
            $display("FAIL done_still_b: b=%h op=%h busy=%b want 22/20/0", data_b, op, busy); else passed++;
        send_byte(8'h20); tick();
        total++; if (tx_start !== 1'b1 || tx_data !== 8'h33)
            $display("FAIL done_frame: start=%b tx=%h want 1/33", tx_start, tx_data); else passed++;
        pulse_done();
        $display("done_edge: a=11 b=22 -> tx=%h", tx_data);
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h44); send_byte(8'h55);
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if ({data_a, data_b, op, tx_data, busy, drop} !== 31'd0)
            $display("FAIL midreset_clear: a=%h b=%h op=%h tx=%h busy=%b drop=%b want all 0",
                     data_a, data_b, op, tx_data, busy, drop);
        else passed++;
        start_count = 0;
        send_byte(8'h09); send_byte(8'h06); send_byte(8'h20);
        total++; if (data_a !== 8'h09 || data_b !== 8'h06)
            $display("FAIL midreset_ops: a=%h b=%h want 09/06", data_a, data_b); else passed++;
        for (int i = 0; i < 8; i++) tick();
        total++; if (start_count !== 1) $display("FAIL midreset_starts: got %0d want 1", start_count); else passed++;
        total++; if (tx_data !== 8'h0F) $display("FAIL midreset_tx: got %h want 0F", tx_data); else passed++;
        $display("midreset: frame 09+06 -> tx=%h starts=%0d", tx_data, start_count);
    endtask

    initial begin
        total = 0; passed = 0; start_count = 0;
        reset = 1'b1; data = 8'h00; valid = 1'b0; tx_done = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_done_edge();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
